// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline types (control bundle, ALUOP codes, ID/EX FSM states)
package id_ex_stage_pkg;
  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} stateT;
  typedef struct packed {
    logic regdst;
    logic alusrc;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } ctrlT;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;
  localparam ctrlT CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load sitting in EX
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  stateT      state,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_writereg,
  input  logic       id_valid,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       haz
);
  assign haz = (state == RUN) & ex_valid & ex_memread & (ex_writereg != 5'd0) & id_valid &
               ((ex_writereg == id_rs) | (id_uses_rt & (ex_writereg == id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush squash and event counters
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic [1:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_writereg,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic [1:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);
  stateT state;
  ctrlT  idCtrl, exCtrl;
  logic  haz;
  assign idCtrl = id_valid ? ctrlT'{regdst: id_regdst, alusrc: id_alusrc, memread: id_memread,
                                    memwrite: id_memwrite, memtoreg: id_memtoreg, regwrite: id_regwrite}
                           : CTRL_NOP;
  assign {ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite} = exCtrl;
  load_use_detect uDetect (
    .state      (state),
    .ex_valid   (ex_valid),
    .ex_memread (exCtrl.memread),
    .ex_writereg(ex_writereg),
    .id_valid   (id_valid),
    .id_uses_rt (id_uses_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .haz        (haz)
  );
  assign stall = haz & ~flush;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      ex_valid    <= 1'b0;
      exCtrl      <= CTRL_NOP;
      ex_aluop    <= ALUOP_ADD;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_writereg <= '0;
      ex_rdata1   <= '0;
      ex_rdata2   <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= stall ? BUBBLE : RUN;
      // a bubble only kills what could change architectural state; data fields are left as they were
      if (flush | stall) begin
        ex_valid        <= 1'b0;
        exCtrl.memread  <= 1'b0;
        exCtrl.memwrite <= 1'b0;
        exCtrl.regwrite <= 1'b0;
        ex_writereg     <= '0;
      end else begin
        ex_valid    <= id_valid;
        exCtrl      <= idCtrl;
        ex_aluop    <= id_valid ? id_aluop : ALUOP_ADD;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_writereg <= id_regdst ? id_rd : id_rt;
        ex_rdata1   <= id_rdata1;
        ex_rdata2   <= id_rdata2;
        ex_imm      <= id_imm;
        ex_pc       <= id_pc;
      end
      stall_count <= cnt_clr ? '0 : stall_count + CNT_W'(stall & ~&stall_count);
      flush_count <= cnt_clr ? '0 : flush_count + CNT_W'(flush & ~&flush_count);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random + directed checks of id_ex_stage against an instruction-slot reference model
module tb_id_ex_stage;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0, reset_n = 1'b1;
  logic id_valid, id_uses_rt, id_regdst, id_alusrc, id_memread, id_memwrite, id_memtoreg, id_regwrite;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] id_aluop;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm, id_pc;
  logic flush, cnt_clr;
  logic stall, ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [4:0] ex_rs, ex_rt, ex_writereg;
  logic [1:0] ex_aluop;
  logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
  logic [CW-1:0] stall_count, flush_count;
  int errors = 0, checks = 0;
  // model of what the EX slot must contain
  logic mValid, mRegdst, mAlusrc, mMemread, mMemwrite, mMemtoreg, mRegwrite, mBub, mFull, sNow;
  logic [4:0] mRs, mRt, mWr;
  logic [1:0] mAluop;
  logic [DW-1:0] mR1, mR2, mImm, mPc;
  int mSc, mFc;
  logic hold;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_aluop(id_aluop),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc(id_pc), .flush(flush),
    .cnt_clr(cnt_clr), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_writereg(ex_writereg), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic expStall();
    return reset_n && !flush && !mBub && mValid && mMemread && (mWr != 5'd0) && id_valid &&
           ((mWr == id_rs) || (id_uses_rt && (mWr == id_rt)));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {mValid, mRegdst, mAlusrc, mMemread, mMemwrite, mMemtoreg, mRegwrite, mBub} = '0;
      {mRs, mRt, mWr, mAluop, mR1, mR2, mImm, mPc} = '0;
      mSc = 0;
      mFc = 0;
      mFull = 1'b1;
    end else begin
      sNow = expStall();
      if (flush || sNow) begin
        mValid = 1'b0; mMemread = 1'b0; mMemwrite = 1'b0; mRegwrite = 1'b0; mWr = 5'd0; mFull = 1'b0;
      end else begin
        mValid = id_valid;
        mRegdst = id_valid && id_regdst;
        mAlusrc = id_valid && id_alusrc;
        mMemread = id_valid && id_memread;
        mMemwrite = id_valid && id_memwrite;
        mMemtoreg = id_valid && id_memtoreg;
        mRegwrite = id_valid && id_regwrite;
        mAluop = id_valid ? id_aluop : 2'b00;
        mRs = id_rs; mRt = id_rt; mWr = id_regdst ? id_rd : id_rt;
        mR1 = id_rdata1; mR2 = id_rdata2; mImm = id_imm; mPc = id_pc;
        mFull = 1'b1;
      end
      mBub = sNow;
      if (cnt_clr) begin mSc = 0; mFc = 0; end
      else begin
        if (sNow && mSc < CMAX) mSc++;
        if (flush && mFc < CMAX) mFc++;
      end
    end
  end

  always @(negedge clk) if (reset_n) begin
    check("stall", stall, expStall());
    check("ex_valid", ex_valid, mValid);
    check("ex_regwrite", ex_regwrite, mRegwrite);
    check("ex_memread", ex_memread, mMemread);
    check("ex_memwrite", ex_memwrite, mMemwrite);
    check("ex_writereg", ex_writereg, mWr);
    check("ex_rs", ex_rs, mRs);
    check("ex_rt", ex_rt, mRt);
    check("ex_rdata1", ex_rdata1, mR1);
    check("ex_rdata2", ex_rdata2, mR2);
    check("ex_imm", ex_imm, mImm);
    check("ex_pc", ex_pc, mPc);
    check("stall_count", stall_count, mSc);
    check("flush_count", flush_count, mFc);
    if (mFull) begin
      check("ex_regdst", ex_regdst, mRegdst);
      check("ex_alusrc", ex_alusrc, mAlusrc);
      check("ex_memtoreg", ex_memtoreg, mMemtoreg);
      check("ex_aluop", ex_aluop, mAluop);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic ur, input logic rdst, input logic mr, input logic rw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur; id_regdst = rdst;
    id_memread = mr; id_memtoreg = mr; id_regwrite = rw; id_alusrc = mr; id_memwrite = 1'b0;
    id_aluop = 2'b00; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_pc = $urandom;
    flush = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic randId();
    id_valid = $urandom_range(0, 9) != 0;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
    id_uses_rt = 1'($urandom); id_regdst = 1'($urandom); id_alusrc = 1'($urandom);
    id_memread = $urandom_range(0, 2) == 0; id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
    id_regwrite = 1'($urandom); id_aluop = 2'($urandom);
    id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_pc = $urandom;
  endtask

  initial begin
    setId(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_wr", ex_writereg, 0);
    check("rst_scnt", stall_count, 0);
    check("rst_fcnt", flush_count, 0);
    #5 reset_n = 1'b1;
    step();
    // load-use: lw $8 then add rs=8
    setId(1, 1, 8, 0, 1, 0, 1, 1); step();
    setId(1, 8, 9, 10, 1, 1, 0, 1); #1 check("lu_stall", stall, 1);
    step();
    check("lu_bub_valid", ex_valid, 0);
    check("lu_bub_rw", ex_regwrite, 0);
    check("lu_bub_stall", stall, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_wr", ex_writereg, 10);
    check("lu_scnt", stall_count, 1);
    // load to $0 never stalls
    setId(1, 1, 0, 0, 1, 0, 1, 1); step();
    setId(1, 0, 2, 3, 1, 1, 0, 1); #1 check("r0_stall", stall, 0);
    step();
    check("r0_valid", ex_valid, 1);
    check("r0_wr", ex_writereg, 3);
    // rt match only counts when rt is a source
    setId(1, 1, 5, 0, 1, 0, 1, 1); step();
    setId(1, 1, 5, 6, 0, 1, 0, 1); #1 check("rt_nouse_stall", stall, 0);
    id_uses_rt = 1'b1; #1 check("rt_use_stall", stall, 1);
    setId(0, 0, 0, 0, 0, 0, 0, 0); step();
    // hazard and flush together
    setId(1, 1, 8, 0, 1, 0, 1, 1); cnt_clr = 1'b1; step();
    setId(1, 8, 9, 10, 1, 1, 0, 1); flush = 1'b1; #1 check("fl_stall", stall, 0);
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_fcnt", flush_count, 1);
    check("fl_scnt", stall_count, 0);
    // saturation, then clear beating a same-cycle stall
    setId(0, 0, 0, 0, 0, 0, 0, 0); cnt_clr = 1'b1; step();
    for (int i = 0; i < 16; i++) begin
      setId(1, 1, 5, 0, 1, 0, 1, 1); step();
      setId(1, 5, 6, 7, 1, 1, 0, 1); step();
      step();
    end
    check("sat_scnt", stall_count, CMAX);
    setId(1, 1, 5, 0, 1, 0, 1, 1); step();
    setId(1, 5, 6, 7, 1, 1, 0, 1); #1 check("sat_more_stall", stall, 1);
    cnt_clr = 1'b1; step();
    check("clr_scnt", stall_count, 0);
    cnt_clr = 1'b0; step();
    // async reset in the middle of a bubble
    setId(1, 1, 5, 0, 1, 0, 1, 1); step();
    setId(1, 5, 6, 7, 1, 1, 0, 1); step();
    check("mid_pre_valid", ex_valid, 0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_scnt", stall_count, 0);
    check("mid_rst_fcnt", flush_count, 0);
    check("mid_rst_stall", stall, 0);
    reset_n = 1'b1;
    step();
    check("mid_run_valid", ex_valid, 1);
    check("mid_run_wr", ex_writereg, 7);
    // randomized traffic; upstream re-presents the instruction it was told to hold
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) randId();
      flush = $urandom_range(0, 9) == 0;
      cnt_clr = $urandom_range(0, 39) == 0;
      #1 hold = stall;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
